// File: rtl/operand_loader_if.sv
// rtl/operand_loader_if.sv - operand loader button/switch inputs and operand outputs
interface operand_loader_if;
  logic       btn;
  logic       clr;
  logic [4:0] sw;
  logic [4:0] a;
  logic [4:0] b;
  logic       ready;
  logic [1:0] phase;

  modport master (
    output btn, clr, sw,
    input  a, b, ready, phase
  );

  modport slave (
    input  btn, clr, sw,
    output a, b, ready, phase
  );
endinterface

// File: rtl/operand_loader.sv
// rtl/operand_loader.sv - debounced push-button loader of two 5-bit subtractor operands
module operand_loader #(
  parameter int DEBOUNCE = 4
) (
  input logic             clk,
  input logic             rst,
  operand_loader_if.slave bus
);

  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    SHOW   = 2'b10
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE - 1);

  logic       sync1;
  logic       btn_s;
  logic       btn_db;
  logic       btn_db_d;
  logic [7:0] cnt;
  logic       press;

  state_t     state, state_nx;
  logic [4:0] a_q, a_nx;
  logic [4:0] b_q, b_nx;
  logic       ready_q, ready_nx;

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      sync1 <= bus.btn;
      btn_s <= sync1;
    end
  end

  // Accept a level change only after DEBOUNCE consecutive differing cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_db   <= 1'b0;
      btn_db_d <= 1'b0;
      cnt      <= 8'd0;
    end else begin
      btn_db_d <= btn_db;
      if (btn_s == btn_db) begin
        cnt <= 8'd0;
      end else if (cnt == CNT_LAST) begin
        btn_db <= btn_s;
        cnt    <= 8'd0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  // One-cycle event on each accepted rising edge of the debounced level.
  assign press = btn_db & ~btn_db_d;

  // State and operand registers; every output comes straight from these.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= LOAD_A;
      a_q     <= 5'd0;
      b_q     <= 5'd0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_nx;
      a_q     <= a_nx;
      b_q     <= b_nx;
      ready_q <= ready_nx;
    end
  end

  // Next state and operand capture; clr wins over a coincident press.
  always_comb begin
    state_nx = state;
    a_nx     = a_q;
    b_nx     = b_q;
    ready_nx = ready_q;
    if (bus.clr) begin
      state_nx = LOAD_A;
      a_nx     = 5'd0;
      b_nx     = 5'd0;
      ready_nx = 1'b0;
    end else if (press) begin
      case (state)
        LOAD_A: begin
          a_nx     = bus.sw;
          state_nx = LOAD_B;
          ready_nx = 1'b0;
        end
        LOAD_B: begin
          b_nx     = bus.sw;
          state_nx = SHOW;
          ready_nx = 1'b1;
        end
        SHOW: begin
          state_nx = LOAD_A;
          ready_nx = 1'b0;
        end
        default: begin
          state_nx = LOAD_A;
          ready_nx = 1'b0;
        end
      endcase
    end
  end

  assign bus.a     = a_q;
  assign bus.b     = b_q;
  assign bus.ready = ready_q;
  assign bus.phase = state;

endmodule

// File: tb/tb_operand_loader.sv
// tb/tb_operand_loader.sv - randomized and directed bench for operand_loader
module tb_operand_loader;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  operand_loader_if bus ();

  operand_loader #(.DEBOUNCE(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural reference: btn_s is btn two edges late; the debounced level
  // follows btn_s once the last D btn_s samples all disagree with it.
  logic       m_started = 1'b0;
  logic [4:0] m_a, m_b;
  logic       m_ready;
  int         m_phase;
  logic       m_db, m_db_d;
  logic       bq0, bq1;
  logic       sq[$];

  always @(posedge clk) begin
    logic bs;
    logic press;
    logic all_diff;
    if (rst) begin
      m_started = 1'b1;
      m_a = 5'd0; m_b = 5'd0; m_ready = 1'b0; m_phase = 0;
      m_db = 1'b0; m_db_d = 1'b0; bq0 = 1'b0; bq1 = 1'b0;
      sq.delete();
      for (int i = 0; i < D; i++) sq.push_back(1'b0);
    end else if (m_started) begin
      bs    = bq1;
      press = m_db && !m_db_d;
      sq.push_back(bs);
      if (sq.size() > D) void'(sq.pop_front());
      all_diff = 1'b1;
      foreach (sq[i]) if (sq[i] == m_db) all_diff = 1'b0;
      m_db_d = m_db;
      if (all_diff) m_db = bs;
      bq1 = bq0;
      bq0 = bus.btn;
      if (bus.clr) begin
        m_a = 5'd0; m_b = 5'd0; m_ready = 1'b0; m_phase = 0;
      end else if (press) begin
        if (m_phase == 0) begin
          m_a = bus.sw; m_phase = 1; m_ready = 1'b0;
        end else if (m_phase == 1) begin
          m_b = bus.sw; m_phase = 2; m_ready = 1'b1;
        end else begin
          m_phase = 0; m_ready = 1'b0;
        end
      end
    end
  end

  task automatic cmp(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Every cycle after the first reset edge, outputs must equal the model.
  always @(negedge clk) begin
    if (m_started) begin
      cmp("model_a", int'(bus.a), int'(m_a));
      cmp("model_b", int'(bus.b), int'(m_b));
      cmp("model_ready", int'(bus.ready), int'(m_ready));
      cmp("model_phase", int'(bus.phase), m_phase);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clean_press(input logic [4:0] v);
    bus.sw  = v;
    bus.btn = 1'b1;
    step(D + 6);
    bus.btn = 1'b0;
    step(D + 6);
  endtask

  task automatic do_clr();
    bus.clr = 1'b1;
    step(1);
    bus.clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.btn = 1'b0;
    bus.clr = 1'b0;
    bus.sw  = 5'd0;
    step(2);
    rst = 1'b0;
    cmp("reset_a", int'(bus.a), 0);
    cmp("reset_b", int'(bus.b), 0);
    cmp("reset_ready", int'(bus.ready), 0);
    cmp("reset_phase", int'(bus.phase), 0);

    // Two clean presses load 13 and 6.
    clean_press(5'd13);
    clean_press(5'd6);
    cmp("load_a13", int'(bus.a), 13);
    cmp("load_b6", int'(bus.b), 6);
    cmp("load_ready", int'(bus.ready), 1);
    cmp("load_phase_show", int'(bus.phase), 2);
    cmp("load_diff", int'(bus.a) - int'(bus.b), 7);

    // SHOW press returns to LOAD_A keeping operands; next press overwrites a only.
    do_clr();
    clean_press(5'd3);
    clean_press(5'd9);
    clean_press(5'd20);
    cmp("show_phase", int'(bus.phase), 0);
    cmp("show_ready", int'(bus.ready), 0);
    cmp("show_keep_a", int'(bus.a), 3);
    cmp("show_keep_b", int'(bus.b), 9);
    clean_press(5'd31);
    cmp("reload_a31", int'(bus.a), 31);
    cmp("reload_b9", int'(bus.b), 9);

    // Capture lands on edge D+3 exactly; a long hold gives one capture.
    do_clr();
    bus.sw  = 5'd21;
    bus.btn = 1'b1;
    step(D + 2);
    cmp("edge6_no_capture", int'(bus.a), 0);
    step(1);
    cmp("edge7_capture", int'(bus.a), 21);
    step(100);
    cmp("hold_phase", int'(bus.phase), 1);
    cmp("hold_a", int'(bus.a), 21);
    bus.btn = 1'b0;
    step(D + 6);

    // Bounce shorter than D produces nothing.
    do_clr();
    for (int i = 0; i < 5; i++) begin
      bus.sw  = 5'(i + 1);
      bus.btn = 1'b1;
      step(2);
      bus.btn = 1'b0;
      step(2);
    end
    step(10);
    cmp("bounce_phase", int'(bus.phase), 0);
    cmp("bounce_a", int'(bus.a), 0);

    // clr on the same edge as a LOAD_B press discards the press.
    do_clr();
    clean_press(5'd4);
    bus.sw  = 5'd17;
    bus.btn = 1'b1;
    step(D + 2);
    bus.clr = 1'b1;
    step(1);
    bus.clr = 1'b0;
    cmp("clr_phase", int'(bus.phase), 0);
    cmp("clr_a", int'(bus.a), 0);
    cmp("clr_b", int'(bus.b), 0);
    cmp("clr_ready", int'(bus.ready), 0);
    step(20);
    bus.btn = 1'b0;
    step(D + 6);
    cmp("clr_no_late_capture", int'(bus.phase), 0);

    // Reset mid-debounce restarts qualification from reset release.
    do_clr();
    bus.sw  = 5'd11;
    bus.btn = 1'b1;
    step(3);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(D + 2);
    cmp("rst_mid_no_capture", int'(bus.a), 0);
    step(1);
    cmp("rst_mid_capture", int'(bus.a), 11);
    bus.btn = 1'b0;
    step(D + 6);

    // Random bouncy button, switches, clears and resets against the model.
    for (int seg = 0; seg < 400; seg++) begin
      int len;
      bus.btn = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 12);
      for (int c = 0; c < len; c++) begin
        bus.sw  = 5'($urandom);
        bus.clr = ($urandom_range(0, 29) == 0);
        rst     = ($urandom_range(0, 199) == 0);
        step(1);
      end
    end
    rst = 1'b0;
    bus.clr = 1'b0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
